// File: rtl/ref_base_streamer_pkg.sv
// Shared types and constants for the reference base streamer.
package ref_base_streamer_pkg;

  // 2-bit nucleotide codes as stored in reference memory.
  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_e;

  localparam int BASES_PER_WORD = 16;

  // Run controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_CAP    = 3'd2,
    ST_STREAM = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

endpackage

// File: rtl/ref_word_unpacker.sv
// Holds the word being drained (cur) and the prefetched word (nxt).
// Bases leave from the top two bits of cur; after the 16th base cur is
// refilled from nxt. If nxt has not arrived, cur goes invalid and is
// filled directly by the late fetch.
module ref_word_unpacker
  import ref_base_streamer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        fill_i,
  input  logic        accept_i,
  input  logic [31:0] word_i,
  output logic        cur_valid_o,
  output logic        nxt_valid_o,
  output logic [1:0]  base_o,
  output logic [3:0]  idx_o
);

  localparam logic [3:0] LAST_IDX = 4'(BASES_PER_WORD - 1);

  logic [31:0] cur_q, cur_d;
  logic [31:0] nxt_q, nxt_d;
  logic        cur_v_q, cur_v_d;
  logic        nxt_v_q, nxt_v_d;
  logic [3:0]  idx_q, idx_d;
  logic        turnover;

  assign turnover    = accept_i && (idx_q == LAST_IDX);
  assign cur_valid_o = cur_v_q;
  assign nxt_valid_o = nxt_v_q;
  assign base_o      = cur_q[31:30];
  assign idx_o       = idx_q;

  // Next-state of the two word slots: clear, first load, shift, turnover, fill.
  always_comb begin
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cur_v_d = cur_v_q;
    nxt_v_d = nxt_v_q;
    idx_d   = idx_q;
    if (clear_i) begin
      cur_v_d = 1'b0;
      nxt_v_d = 1'b0;
      idx_d   = 4'd0;
    end else if (load_i) begin
      cur_d   = word_i;
      cur_v_d = 1'b1;
      nxt_v_d = 1'b0;
      idx_d   = 4'd0;
    end else if (turnover) begin
      idx_d = 4'd0;
      if (nxt_v_q) begin
        cur_d   = nxt_q;
        cur_v_d = 1'b1;
        nxt_v_d = 1'b0;
      end else if (fill_i) begin
        cur_d   = word_i;
        cur_v_d = 1'b1;
      end else begin
        cur_v_d = 1'b0;
      end
    end else begin
      if (accept_i) begin
        cur_d = {cur_q[29:0], 2'b00};
        idx_d = idx_q + 4'd1;
      end
      if (fill_i) begin
        if (cur_v_q) begin
          nxt_d   = word_i;
          nxt_v_d = 1'b1;
        end else begin
          cur_d   = word_i;
          cur_v_d = 1'b1;
          idx_d   = 4'd0;
        end
      end
    end
  end

  // Word slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q   <= '0;
      nxt_q   <= '0;
      cur_v_q <= 1'b0;
      nxt_v_q <= 1'b0;
      idx_q   <= 4'd0;
    end else begin
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      cur_v_q <= cur_v_d;
      nxt_v_q <= nxt_v_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/ref_base_streamer.sv
// Streams a run of packed 2-bit bases from reference memory, one per cycle.
// Handshake: a base moves when base_valid && base_ready on a rising edge;
// base_data/base_last hold while base_valid && !base_ready.
// A fetch is a two-stage pipe: mem_addr is registered (fetch_a), the memory
// answers one cycle later (fetch_b), and the word is captured on that edge.
module ref_base_streamer
  import ref_base_streamer_pkg::*;
#(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len_bases,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [1:0]            base_data,
  output logic                  base_valid,
  input  logic                  base_ready,
  output logic                  base_last,
  output logic [2:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_SIZE);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  fetch_a_q, fetch_a_d;
  logic                  fetch_b_q, fetch_b_d;

  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic [ADDR_WIDTH-1:0] word_addr_inc;
  logic [LEN_WIDTH-1:0]  left_in_cur;
  logic                  cur_valid, nxt_valid;
  logic [1:0]            cur_base;
  logic [3:0]            cur_idx;
  logic                  accept, prefetch;
  logic                  unp_clear, unp_load, unp_fill;

  assign aligned_addr  = base_addr & ~ADDR_WIDTH'(3);
  assign word_addr_inc = (word_addr_q + ADDR_WIDTH'(4)) % MEM_BYTES;
  assign left_in_cur   = cur_valid ? (LEN_WIDTH'(BASES_PER_WORD) - LEN_WIDTH'(cur_idx)) : '0;

  assign base_valid = (state_q == ST_STREAM) && cur_valid;
  assign base_data  = base_valid ? cur_base : BASE_A;
  assign base_last  = base_valid && (remaining_q == LEN_WIDTH'(1));
  assign accept     = base_valid && base_ready;
  assign busy       = (state_q == ST_REQ) || (state_q == ST_CAP) || (state_q == ST_STREAM);
  assign done       = (state_q == ST_FIN);
  assign mem_addr   = mem_addr_q;
  assign dbg_state  = state_q;

  // Fetch the next word only when it will be needed and nothing is pending.
  assign prefetch = (state_q == ST_STREAM) && !abort && !nxt_valid &&
                    !fetch_a_q && !fetch_b_q && (remaining_q > left_in_cur);

  assign unp_clear = abort || !((state_q == ST_CAP) || (state_q == ST_STREAM));
  assign unp_load  = (state_q == ST_CAP);
  assign unp_fill  = fetch_b_q && (state_q == ST_STREAM);

  ref_word_unpacker u_unpacker (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (unp_clear),
    .load_i      (unp_load),
    .fill_i      (unp_fill),
    .accept_i    (accept),
    .word_i      (mem_dout[31:0]),
    .cur_valid_o (cur_valid),
    .nxt_valid_o (nxt_valid),
    .base_o      (cur_base),
    .idx_o       (cur_idx)
  );

  // Run controller next state, address generation and fetch pipe.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_addr_d = word_addr_q;
    mem_addr_d  = mem_addr_q;
    fetch_a_d   = 1'b0;
    fetch_b_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = len_bases;
          if (len_bases == '0) begin
            state_d = ST_FIN;
          end else begin
            word_addr_d = aligned_addr;
            mem_addr_d  = aligned_addr;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: state_d = ST_CAP;
      ST_CAP: begin
        word_addr_d = word_addr_inc;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        fetch_b_d = fetch_a_q;
        if (accept) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = ST_FIN;
        end
        if (prefetch) begin
          mem_addr_d  = word_addr_q;
          word_addr_d = word_addr_inc;
          fetch_a_d   = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      fetch_a_d = 1'b0;
      fetch_b_d = 1'b0;
    end
  end

  // Controller registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      word_addr_q <= '0;
      mem_addr_q  <= '0;
      fetch_a_q   <= 1'b0;
      fetch_b_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_addr_q <= word_addr_d;
      mem_addr_q  <= mem_addr_d;
      fetch_a_q   <= fetch_a_d;
      fetch_b_q   <= fetch_b_d;
    end
  end

endmodule

// File: tb/tb_ref_base_streamer.sv
// Bench for ref_base_streamer: behavioural memory, reference base queue,
// stall-stability and address-range monitors, directed and random runs.
module tb_ref_base_streamer;

  localparam int MEM_SIZE = 4096;
  localparam int AW       = 32;
  localparam int LW       = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len_bases;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dout;
  logic [1:0]    base_data;
  logic          base_valid;
  logic          base_ready;
  logic          base_last;
  logic [2:0]    dbg_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  ref_base_streamer #(
    .MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .len_bases(len_bases), .abort(abort), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .base_data(base_data),
    .base_valid(base_valid), .base_ready(base_ready), .base_last(base_last),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model (registered read) ----------------
  logic [31:0] mem [0:MEM_SIZE/4-1];
  always @(posedge clk) mem_dout <= mem[mem_addr[11:2]];

  // ---------------- scoreboard state ----------------
  logic [1:0]  exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          nc = 0;
  int          acc_cnt, first_valid_nc, last_acc_nc;
  bit          seen_valid;
  logic [AW-1:0] run_aligned;
  int          run_len = 0;
  int          ready_mode = 0;
  int          rk = 0;
  logic [3:0]  ready_pat = 4'b1001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: base i of a run lives in word (i/16), bits big-endian.
  task automatic build_expected(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] wa;
    logic [31:0]   w;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      wa = ((addr & ~32'd3) + 32'(4 * (i / 16))) % MEM_SIZE;
      w  = mem[wa / 4];
      exp_q.push_back(2'(w >> (30 - 2 * (i % 16))));
    end
  endtask

  function automatic logic [AW-1:0] last_word_addr(input logic [AW-1:0] addr, input int len);
    return ((addr & ~32'd3) + 32'(4 * ((len - 1) / 16))) % MEM_SIZE;
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    base_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: base_ready = 1'b1;
        1: begin base_ready = ready_pat[3 - (rk % 4)]; rk++; end
        default: base_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor (samples on falling edge) ----------------
  logic       p_stall = 1'b0;
  logic [1:0] p_data;
  logic       p_last;
  initial begin
    int         sz;
    logic [1:0] e;
    logic [31:0] off;
    forever begin
      @(negedge clk);
      nc++;
      if (reset_n) begin
        if (p_stall) begin
          check("stall_valid", base_valid, 1);
          check("stall_data", base_data, p_data);
          check("stall_last", base_last, p_last);
        end
        if (!base_valid) check("last_no_valid", base_last, 0);
        if (busy && run_len > 0) begin
          off = (mem_addr - run_aligned) & 32'(MEM_SIZE - 1);
          check("mem_addr_range", 32'((off[1:0] == 2'b00) && (off / 4 <= 32'((run_len - 1) / 16))), 1);
        end
        if (base_valid && !seen_valid) begin
          seen_valid     = 1'b1;
          first_valid_nc = nc;
        end
        if (base_valid && base_ready) begin
          sz = exp_q.size();
          if (sz == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            check("base_last", base_last, 32'(sz == 1));
            e = exp_q.pop_front();
            check("base_data", base_data, e);
          end
          acc_cnt++;
          last_acc_nc = nc;
        end
      end
      p_stall = reset_n && !abort && base_valid && !base_ready;
      p_data  = base_data;
      p_last  = base_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [AW-1:0] addr, input int len, input bit with_abort);
    run_aligned = addr & ~32'd3;
    run_len     = len;
    acc_cnt     = 0;
    seen_valid  = 1'b0;
    rk          = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = addr; len_bases = LW'(len); abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    base_addr = $urandom; len_bases = LW'($urandom);
  endtask

  task automatic run(input logic [AW-1:0] addr, input int len, input int mode,
                     input bit chk_gap, input bit with_abort);
    int c;
    ready_mode = mode;
    build_expected(addr, len);
    issue_start(addr, len, with_abort);
    step();
    if (len == 0) begin
      check("zl_done", done, 1);
      check("zl_busy", busy, 0);
      step();
      check("zl_done_drop", done, 0);
      check("zl_busy_after", busy, 0);
      check("zl_no_valid", 32'(seen_valid), 0);
      run_len = 0;
      return;
    end
    check("busy_e0", busy, 1);
    check("mem_addr_e0", mem_addr, addr & ~32'd3);
    check("valid_e0", base_valid, 0);
    step();
    check("valid_e1", base_valid, 0);
    step();
    check("valid_e2", base_valid, 1);
    c = 0;
    while (!done && c < 2000) begin step(); c++; end
    check("done_seen", done, 1);
    if (done) begin
      check("done_after_last", nc, last_acc_nc + 1);
      check("busy_at_done", busy, 0);
      check("accept_count", acc_cnt, len);
      check("exp_empty", exp_q.size(), 0);
      check("mem_addr_last", mem_addr, last_word_addr(addr, len));
      if (chk_gap) check("no_gap", last_acc_nc - first_valid_nc, len - 1);
    end
    step();
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    exp_q.delete();
    run_len = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, base_valid, 0);
    check({tag, "_last"}, base_last, 0);
    check({tag, "_data"}, base_data, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    logic [AW-1:0] ra;
    int rl, rm;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; len_bases = '0;
    for (int i = 0; i < MEM_SIZE / 4; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    step();
    check_reset_outputs("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // Repeating ACGT pattern in one word.
    mem[0] = 32'h1B1B1B1B;
    run(32'h0, 16, 0, 1, 0);

    // All-A word then all-T word across a word boundary.
    mem[32'h100 / 4] = 32'h0000_0000;
    mem[32'h104 / 4] = 32'hFFFF_FFFF;
    run(32'h100, 20, 0, 1, 0);
    run(32'h100, 20, 1, 0, 0);

    // Zero-length run.
    run(32'h55, 0, 0, 0, 0);

    // Address wrap at the top of memory.
    run(32'(MEM_SIZE - 4), 32, 0, 1, 0);

    // Start together with abort while idle: start wins.
    run(32'h200, 17, 0, 1, 1);

    // Low address bits ignored.
    run(32'h203, 5, 2, 0, 0);

    // Random runs.
    for (int r = 0; r < 8; r++) begin
      ra = 32'($urandom_range(0, MEM_SIZE - 1));
      rl = $urandom_range(1, 60);
      rm = $urandom_range(0, 2);
      run(ra, rl, rm, rm == 0, 0);
    end

    // Abort after the fifth beat of a 40-base run.
    ready_mode = 0;
    build_expected(32'h300, 40);
    issue_start(32'h300, 40, 0);
    c = 0;
    while (acc_cnt < 5 && c < 200) begin step(); c++; end
    check("abort_reach_beat5", 32'(acc_cnt >= 5), 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    step();
    check("abort_valid", base_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, 0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", done, 0);
      step();
    end
    exp_q.delete();
    run_len = 0;

    // Reset in the middle of a second run.
    ready_mode = 2;
    build_expected(32'h400, 40);
    issue_start(32'h400, 40, 0);
    repeat (12) step();
    check("pre_reset_busy", busy, 1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    step();
    check_reset_outputs("held_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    exp_q.delete();
    run_len = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset_no_done", done, 0);
    end

    // Recovery run after reset.
    run(32'h40, 33, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ref_base_streamer.md
# ref_base_streamer

- Fetches a run of packed 2-bit nucleotides from the reference memory's read port.
- Unpacks each 32-bit word big-endian: first base in bits [31:30], sixteen bases per word.
- Emits the bases one per cycle on a valid/ready stream to the downstream alignment datapath.
- Sits between the sequencer, which issues start/address/length, and the consumer of the reference stream; prefetches one word ahead so the stream has no gaps.

## Interface
Parameters:
- MEM_SIZE, 4096: reference memory size in bytes; word addresses wrap modulo MEM_SIZE.
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: memory word width; fixed at 32 (16 bases).
- LEN_WIDTH, 20: width of the base-count field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- base_addr  in  ADDR_WIDTH  byte address of first word; bits [1:0] ignored.
- len_bases  in  LEN_WIDTH  number of bases to emit.
- abort  in  1  synchronous cancel of the current run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse after the last base is accepted, or after a zero-length run.
- mem_addr  out  ADDR_WIDTH  byte read address to the memory port; memory returns data one cycle later (registered read).
- mem_dout  in  DATA_WIDTH  read data from the memory.
- base_data  out  2  nucleotide code.
- base_valid  out  1  base_data valid.
- base_ready  in  1  consumer accepts when valid && ready.
- base_last  out  1  marks the final base of the run.

## Operation
- States:
  - IDLE
  - REQ: mem_addr driven for the first word.
  - CAP: first word captured at the end of this cycle.
  - STREAM
  - FIN: done pulse.
- IDLE:
  - start with len_bases==0 → FIN.
  - start with len_bases!=0 → REQ. Latch addr = {base_addr[ADDR_WIDTH-1:2],2'b00}, remaining = len_bases.
- REQ → CAP unconditionally. CAP → STREAM after loading cur_word from mem_dout. word_addr advances by 4.
- Data path: two word registers, cur_word and nxt_word, each with a valid flag.
- STREAM output: base_data = cur_word[31:30]. On each accepted beat:
  - cur_word shifts left 2.
  - base index increments (0..15).
  - remaining decrements.
- Prefetch:
  - Trigger, in STREAM: nxt empty, no fetch in flight, and words still needed (remaining > bases left in cur_word).
  - Drive mem_addr = word_addr for one cycle; capture mem_dout into nxt_word on the following edge.
  - word_addr += 4, modulo MEM_SIZE.
- Word turnover: on acceptance of base index 15, cur_word ← nxt_word and nxt becomes empty. If nxt is not yet valid (only possible under reset-free corner misuse), base_valid deasserts until it is.
- base_last = base_valid && remaining==1. Its acceptance → FIN.
- FIN: done=1 for one cycle → IDLE.
- abort in any non-IDLE state → IDLE next cycle. base_valid drops, no done, an in-flight fetch is discarded.
- Simultaneous start and abort while IDLE: start wins.
- When not fetching, mem_addr holds its last value. The memory has no enable, so holding is harmless.

## Timing
- Reset values: busy=0, done=0, base_valid=0, base_last=0, base_data=0, mem_addr=0, state IDLE.
- Reset mid-run clears everything immediately; no done.
- Latency:
  - start sampled at edge E0 → mem_addr valid after E0 → base_valid high after E2 (3 cycles).
  - len 0 → done high after E0, busy stays 0.
- Throughput: 1 base/cycle with base_ready held high, no bubbles across word boundaries. The 2-cycle fetch is hidden by 16-cycle word drain.
- base_data and base_last stay stable while base_valid && !base_ready.
- busy is high from the cycle after start through the cycle before done.

## Structure
- Shared package holds:
  - base codes A=2'b00, C=2'b01, G=2'b10, T=2'b11.
  - BASES_PER_WORD=16.
  - State encoding.
- A sub-module is natural: ref_word_unpacker (cur_word shift register + index + turnover from nxt_word). The FSM and address generator stay in the top.

## Test plan
- Memory word 0 = 0x1B1B1B1B. start, addr 0, len 16, ready=1 → bases 0,1,2,3 ×4 on consecutive cycles. First valid 3 cycles after start. base_last on the 16th beat; done one cycle later.
- Words 0x00000000 and 0xFFFFFFFF at 0x100/0x104, len 20 → sixteen 0s then four 3s with no bubble. mem_addr reads only 0x100 and 0x104.
- Same run with base_ready toggling 1,0,0,1 → identical base sequence, outputs stable during stalls, total 20 accepts.
- len 0 → done pulse one cycle after start, base_valid never rises, busy stays 0.
- addr = MEM_SIZE-4, len 32 → second fetch at mem_addr 0 (wrap).
- abort at beat 5 of a len-40 run, then reset_n low mid-second run → valid drops next cycle with no done; all outputs are reset values while reset_n=0.
